axb_seq_engine: RTL and testbench

- Sequential evaluator of y = a*x + b using a shift-add multiplier.
- Sits directly downstream of the memory-mapped coefficient peripheral.
- Consumes that peripheral's stored a, b and x fields and returns y, with status, for readback at the peripheral's result address.
- Replaces a purely combinational a*x + b path with a multi-cycle, handshaked datapath.

---
 rtl/axb_seq_engine.sv | 105 ++++++++++
 tb/tb_axb_seq_engine.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axb_seq_engine.sv
// Multi-cycle evaluator of y = a*x + b: WIDTH shift-add edges, then one add edge.
// Operands are latched at start, so input changes mid-operation never reach the result.
module axb_seq_engine #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    input  logic [WIDTH-1:0]     iX,
    output logic [2*WIDTH-1:0]   oY,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [CNT_W-1:0]     oCount
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;

    logic [1:0]           r_state;
    logic [BIT_W-1:0]     r_bit;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_W-1:0]     r_count;
    logic [2*WIDTH-1:0]   r_y;
    logic [2*WIDTH-1:0]   r_acc;

    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_b;

    logic                 w_accept;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_addend;

    assign w_accept = (r_state == S_IDLE) && iStart;
    assign w_last   = (r_bit == BIT_W'(WIDTH - 1));
    // a is pre-shifted and x consumed LSB-first, so bit k of x always sits at r_x[0]
    assign w_addend = r_x[0] ? r_mcand : '0;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_y     <= '0;
            r_acc   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_acc   <= '0;
                        r_bit   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc <= r_acc + w_addend;
                    r_bit <= r_bit + BIT_W'(1);
                    if (w_last) begin
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_y     <= r_acc + {{WIDTH{1'b0}}, r_b};
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_count <= r_count + CNT_W'(1);
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand registers carry data only; they are always reloaded before use.
    always_ff @(posedge iClk) begin
        if (w_accept) begin
            r_mcand <= {{WIDTH{1'b0}}, iA};
            r_x     <= iX;
            r_b     <= iB;
        end else if (r_state == S_MUL) begin
            r_mcand <= r_mcand << 1;
            r_x     <= r_x >> 1;
        end
    end

    assign oY     = r_y;
    assign oBusy  = r_busy;
    assign oDone  = r_done;
    assign oCount = r_count;

endmodule

// File: tb/tb_axb_seq_engine.sv
// Scoreboard bench for axb_seq_engine: stimulus pushes expected completions,
// a negedge monitor compares every cycle against the model's view of the outputs.
module tb_axb_seq_engine;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic                 iClk = 1'b0;
    logic                 iReset;
    logic                 iStart;
    logic [WIDTH-1:0]     iA;
    logic [WIDTH-1:0]     iB;
    logic [WIDTH-1:0]     iX;
    logic [2*WIDTH-1:0]   oY;
    logic                 oBusy;
    logic                 oDone;
    logic [CNT_W-1:0]     oCount;

    axb_seq_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .iStart (iStart),
        .iA     (iA),
        .iB     (iB),
        .iX     (iX),
        .oY     (oY),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oCount (oCount)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int passes = 0;
    int edge_n = 0;
    bit mon_en = 1'b0;

    int q_y[$];
    int q_cnt[$];
    int q_cyc[$];

    int exp_y = 0;
    int exp_cnt = 0;
    int issued_cnt = 0;
    int busy_from = 0;
    int busy_to = -1;
    int next_free = 0;
    bit mon_dexp;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    // One clock edge: drive inputs, then update the model with what that edge must do.
    task automatic step(input bit rst, input bit st, input int a, input int b, input int x);
        int am, bm, xm;
        am = a % (1 << WIDTH);
        bm = b % (1 << WIDTH);
        xm = x % (1 << WIDTH);
        iReset = rst;
        iStart = st;
        iA = am[WIDTH-1:0];
        iB = bm[WIDTH-1:0];
        iX = xm[WIDTH-1:0];
        @(posedge iClk);
        edge_n++;
        if (rst) begin
            q_y.delete();
            q_cnt.delete();
            q_cyc.delete();
            exp_y = 0;
            exp_cnt = 0;
            issued_cnt = 0;
            busy_to = -1;
            next_free = edge_n + 1;
        end else if (st && edge_n >= next_free) begin
            issued_cnt = (issued_cnt + 1) % (1 << CNT_W);
            q_y.push_back(am * xm + bm);
            q_cnt.push_back(issued_cnt);
            q_cyc.push_back(edge_n + WIDTH + 1);
            busy_from = edge_n;
            busy_to = edge_n + WIDTH;
            next_free = edge_n + WIDTH + 2;
        end
        @(negedge iClk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    always @(negedge iClk) begin
        if (mon_en) begin
            mon_dexp = (q_cyc.size() > 0) && (q_cyc[0] == edge_n);
            check("done", int'(oDone), int'(mon_dexp));
            if (mon_dexp) begin
                exp_y = q_y.pop_front();
                exp_cnt = q_cnt.pop_front();
                void'(q_cyc.pop_front());
            end
            check("y", int'(oY), exp_y);
            check("count", int'(oCount), exp_cnt);
            check("busy", int'(oBusy), int'(busy_from <= edge_n && edge_n <= busy_to));
        end
    end

    initial begin
        iReset = 1'b1;
        iStart = 1'b0;
        iA = '0;
        iB = '0;
        iX = '0;
        step(1'b1, 1'b0, 0, 0, 0);
        step(1'b1, 1'b1, 7, 7, 7);
        check("rst_y", int'(oY), 0);
        check("rst_busy", int'(oBusy), 0);
        check("rst_done", int'(oDone), 0);
        check("rst_count", int'(oCount), 0);
        mon_en = 1'b1;

        step(1'b0, 1'b1, 3, 2, 5);
        idle(7);
        check("basic_y", int'(oY), 17);
        check("basic_count", int'(oCount), 1);

        step(1'b0, 1'b1, 15, 15, 15);
        idle(6);
        check("max_y", int'(oY), 240);
        step(1'b0, 1'b1, 9, 7, 0);
        idle(6);
        check("xzero_y", int'(oY), 7);
        step(1'b0, 1'b1, 0, 0, 0);
        idle(6);
        check("zero_y", int'(oY), 0);
        check("zero_count", int'(oCount), 4);

        // Second start and an operand change while busy must both be ignored.
        step(1'b0, 1'b1, 2, 1, 3);
        step(1'b0, 1'b1, 15, 1, 3);
        step(1'b0, 1'b1, 15, 9, 9);
        idle(6);
        check("busy_y", int'(oY), 7);
        check("busy_count", int'(oCount), 5);

        // Start sampled on the edge right after the done cycle begins.
        step(1'b0, 1'b1, 1, 0, 1);
        idle(5);
        step(1'b0, 1'b1, 4, 4, 4);
        idle(4);
        step(1'b0, 1'b0, 0, 0, 0);
        check("b2b_y", int'(oY), 20);
        check("b2b_count", int'(oCount), 7);

        step(1'b0, 1'b1, 5, 1, 5);
        step(1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0);
        idle(7);
        check("abort_y", int'(oY), 0);
        check("abort_count", int'(oCount), 0);
        step(1'b0, 1'b1, 5, 1, 5);
        idle(6);
        check("restart_y", int'(oY), 26);

        // 256 completions from a fresh reset; start held high with random operands.
        step(1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 256 * (WIDTH + 2); i++)
            step(1'b0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        step(1'b0, 1'b0, 0, 0, 0);
        idle(8);
        check("wrap_count", int'(oCount), 0);

        for (int i = 0; i < 400; i++)
            step(1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
        idle(10);
        check("drain", q_cyc.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
